column_scheduler: RTL

Sequencing controller for the three falling-letter columns of the Flippy Bit game. It generates the per-column hold-reset lines and fall-step enables. It staggers column spawns, speeds up the fall rate as score rises, respawns a column on a correct answer, and freezes everything on game over. It sits between the game state machine and the column instances, and replaces free-running per-column timing with a single shared, score-driven time base.

---
 rtl/flippy_pkg.sv | 15 +
 rtl/step_divider.sv | 60 ++++++
 rtl/column_scheduler.sv | 132 +++++++++++++
 3 files changed

// File: rtl/flippy_pkg.sv
// rtl/flippy_pkg.sv - shared constants and state encoding for the Flippy Bit column scheduler
package flippy_pkg;

  localparam int NUM_COLS = 3;
  localparam int LEVEL_W  = 4;
  localparam logic [LEVEL_W-1:0] MAX_LEVEL = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SPAWN = 2'd1,
    ST_RUN   = 2'd2,
    ST_OVER  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/step_divider.sv
// rtl/step_divider.sv - shared fall-step time base with level-driven, clamped period
// The period is relatched only on clear or at a step, so a level change never cuts a period short.
import flippy_pkg::*;

module step_divider #(
  parameter int DIV_W          = 26,
  parameter int TICK_DIV_START = 25000000,
  parameter int TICK_DIV_MIN   = 5000000,
  parameter int TICK_DIV_STEP  = 1250000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               enable_i,
  input  logic [LEVEL_W-1:0] level_i,
  output logic               step_tick_o
);

  localparam int PROD_W = DIV_W + LEVEL_W;
  localparam logic [PROD_W-1:0] START_W = PROD_W'(TICK_DIV_START);
  localparam logic [PROD_W-1:0] MIN_W   = PROD_W'(TICK_DIV_MIN);
  localparam logic [PROD_W-1:0] STEP_W  = PROD_W'(TICK_DIV_STEP);

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  div_calc;
  logic [PROD_W-1:0] cut;
  logic [PROD_W-1:0] remain;

  // Saturating subtract, then floor at the minimum period.
  always_comb begin
    cut      = PROD_W'(level_i) * STEP_W;
    remain   = (START_W > cut) ? (START_W - cut) : '0;
    div_calc = (remain > MIN_W) ? DIV_W'(remain) : DIV_W'(TICK_DIV_MIN);
  end

  assign step_tick_o = enable_i && (cnt_q == (div_q - DIV_W'(1)));

  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    if (clear_i || step_tick_o) begin
      cnt_d = '0;
      div_d = div_calc;
    end else if (enable_i) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      div_q <= DIV_W'(TICK_DIV_START);
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/column_scheduler.sv
// rtl/column_scheduler.sv - staggered spawn, score-driven fall steps, respawn and game-over freeze
// Optional stall input enabled by COLUMN_SCHED_PAUSE_EN.
import flippy_pkg::*;

module column_scheduler #(
  parameter int NUM_COLS       = flippy_pkg::NUM_COLS,
  parameter int DIV_W          = 26,
  parameter int TICK_DIV_START = 25000000,
  parameter int TICK_DIV_MIN   = 5000000,
  parameter int TICK_DIV_STEP  = 1250000,
  parameter int SPAWN_GAP      = 4,
  parameter int LEVEL_SHIFT    = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          score,
  input  logic [NUM_COLS-1:0] game_over,
  input  logic [NUM_COLS-1:0] correct,
`ifdef COLUMN_SCHED_PAUSE_EN
  input  logic                pause,
`endif
  output logic [NUM_COLS-1:0] col_reset,
  output logic [NUM_COLS-1:0] fall_tick,
  output logic [LEVEL_W-1:0]  level,
  output logic [1:0]          state_out
);

  localparam int SPAWN_W = 8;

  sched_state_e        state_q, state_d;
  logic [NUM_COLS-1:0] released_q, released_d;
  logic [NUM_COLS-1:0] col_reset_q, col_reset_d;
  logic [NUM_COLS-1:0] fall_tick_q, fall_tick_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic [SPAWN_W-1:0]  spawn_q, spawn_d;
  logic [NUM_COLS-1:0] respawn;
  logic [7:0]          score_lvl;
  logic                div_clear;
  logic                div_en;
  logic                step_tick;
  logic                pause_w;

`ifdef COLUMN_SCHED_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  step_divider #(
    .DIV_W          (DIV_W),
    .TICK_DIV_START (TICK_DIV_START),
    .TICK_DIV_MIN   (TICK_DIV_MIN),
    .TICK_DIV_STEP  (TICK_DIV_STEP)
  ) u_step_divider (
    .clock       (clock),
    .reset       (reset),
    .clear_i     (div_clear),
    .enable_i    (div_en),
    .level_i     (level_q),
    .step_tick_o (step_tick)
  );

  always_comb begin
    score_lvl = score >> LEVEL_SHIFT;
    level_d   = (score_lvl > 8'(MAX_LEVEL)) ? MAX_LEVEL : score_lvl[LEVEL_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    released_d  = released_q;
    spawn_d     = spawn_q;
    respawn     = '0;
    fall_tick_d = '0;
    div_clear   = 1'b0;
    div_en      = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        div_clear = (state_q == ST_IDLE) || start;
        if (start) begin
          state_d    = ST_SPAWN;
          released_d = NUM_COLS'(1);
          spawn_d    = '0;
        end
      end
      ST_SPAWN, ST_RUN: begin
        div_en = ~pause_w;
        if (|game_over) begin
          state_d    = ST_OVER;
          released_d = '0;
        end else begin
          // A respawn only applies to columns already falling.
          respawn     = correct & released_q;
          fall_tick_d = {NUM_COLS{step_tick}} & ~col_reset_q & ~respawn;
          if ((state_q == ST_SPAWN) && step_tick) begin
            spawn_d = spawn_q + SPAWN_W'(1);
            for (int k = 1; k < NUM_COLS; k++) begin
              if (spawn_d == SPAWN_W'(k * SPAWN_GAP)) released_d[k] = 1'b1;
            end
            if (&released_d) state_d = ST_RUN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    col_reset_d = ~released_d | respawn;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      released_q  <= '0;
      col_reset_q <= '1;
      fall_tick_q <= '0;
      level_q     <= '0;
      spawn_q     <= '0;
    end else begin
      state_q     <= state_d;
      released_q  <= released_d;
      col_reset_q <= col_reset_d;
      fall_tick_q <= fall_tick_d;
      level_q     <= level_d;
      spawn_q     <= spawn_d;
    end
  end

  assign col_reset = col_reset_q;
  assign fall_tick = fall_tick_q;
  assign level     = level_q;
  assign state_out = state_q;

endmodule
